// File: rtl/reg_xfer_seq.sv
// Register-transfer sequencer for the 8080 register array: runs MOV/MVI/INR/DCR
// through READ/WRITE phases on the shared internal bus and keeps Z/S flags.
module reg_xfer_seq #(
  parameter int         BUS_W  = 8,
  parameter logic [2:0] M_CODE = 3'd6
) (
  input  logic             clk50M_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [1:0]       op_i,
  input  logic [2:0]       dst_i,
  input  logic [2:0]       src_i,
  input  logic [BUS_W-1:0] imm_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             err_o,
  output logic [7:0]       latch_rd_o,
  output logic [7:0]       latch_wr_o,
  input  logic [BUS_W-1:0] bus_i,
  output logic [BUS_W-1:0] bus_o,
  output logic             bus_oe_o,
  output logic             flag_z_o,
  output logic             flag_s_o
);

  // state   | meaning
  // S_IDLE  | waiting for a request, ready_o high
  // S_READ  | source register on the bus, TMP captures (optionally +/-1)
  // S_WRITE | TMP driven on the bus, destination write strobe high
  // S_RESP  | done pulse
  // S_ERR   | done + err pulse for a rejected request
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_RESP, S_ERR} state_t;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_INR = 2'b10;
  localparam logic [1:0] OP_DCR = 2'b11;

  state_t           state;
  logic [1:0]       op_q;
  logic [2:0]       dst_q;
  logic [2:0]       src_q;
  logic [BUS_W-1:0] tmp;
  logic [BUS_W-1:0] bus_q;
  logic [7:0]       latch_rd;
  logic [7:0]       latch_wr;
  logic             bus_oe;
  logic             done;
  logic             err;
  logic             flag_z;
  logic             flag_s;

  logic             reject;
  logic [BUS_W-1:0] rd_val;

  function automatic logic [7:0] onehot(input logic [2:0] code);
    onehot = 8'd1 << code;
  endfunction

  // memory operand is handled elsewhere; src only matters for MOV
  always_comb begin
    reject = (dst_i == M_CODE);
    if (op_i == OP_MOV && src_i == M_CODE)
      reject = 1'b1;
  end

  always_comb begin
    case (op_q)
      OP_INR:  rd_val = bus_i + BUS_W'(1);
      OP_DCR:  rd_val = bus_i - BUS_W'(1);
      default: rd_val = bus_i;
    endcase
  end

  always_ff @(posedge clk50M_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      tmp      <= '0;
      bus_q    <= '0;
      latch_rd <= '0;
      latch_wr <= '0;
      bus_oe   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      flag_z   <= 1'b0;
      flag_s   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i) begin
            op_q  <= op_i;
            dst_q <= dst_i;
            src_q <= src_i;
            if (reject) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_ERR;
            end else if (op_i == OP_MVI) begin
              tmp      <= imm_i;
              bus_q    <= imm_i;
              bus_oe   <= 1'b1;
              latch_wr <= onehot(dst_i);
              state    <= S_WRITE;
            end else begin
              latch_rd <= onehot((op_i == OP_MOV) ? src_i : dst_i);
              state    <= S_READ;
            end
          end
        end
        S_READ: begin
          // read strobe drops on the same edge the write phase starts, so the
          // bus never has two drivers
          tmp      <= rd_val;
          bus_q    <= rd_val;
          latch_rd <= '0;
          latch_wr <= onehot(dst_q);
          bus_oe   <= 1'b1;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (op_q == OP_INR || op_q == OP_DCR) begin
            flag_z <= (tmp == '0);
            flag_s <= tmp[BUS_W-1];
          end
          latch_wr <= '0;
          bus_oe   <= 1'b0;
          bus_q    <= '0;
          done     <= 1'b1;
          state    <= S_RESP;
        end
        S_RESP: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o    = (state == S_IDLE) && !rst_i;
  assign done_o     = done;
  assign err_o      = err;
  assign latch_rd_o = latch_rd;
  assign latch_wr_o = latch_wr;
  assign bus_o      = bus_q;
  assign bus_oe_o   = bus_oe;
  assign flag_z_o   = flag_z;
  assign flag_s_o   = flag_s;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Bench for reg_xfer_seq: a register bank driven by the strobes, a directed
// vector table, a reset-in-WRITE sequence and randomized traffic against a model.
module tb_reg_xfer_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [1:0] op  = '0;
  logic [2:0] dst = '0;
  logic [2:0] src = '0;
  logic [7:0] imm = '0;
  logic       ready, done, err;
  logic [7:0] rd, wr, bus_i, bus_o;
  logic       oe, fz, fs;

  reg_xfer_seq #(.BUS_W(8), .M_CODE(3'd6)) dut (
    .clk50M_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .dst_i(dst),
    .src_i(src), .imm_i(imm), .ready_o(ready), .done_o(done), .err_o(err),
    .latch_rd_o(rd), .latch_wr_o(wr), .bus_i(bus_i), .bus_o(bus_o),
    .bus_oe_o(oe), .flag_z_o(fz), .flag_s_o(fs)
  );

  always #10 clk = ~clk;

  int total = 0;
  int passed = 0;
  int inv_err = 0;
  int done_cnt = 0;

  // register slices reacting to the sequencer's strobes
  logic [7:0] bank [8];
  initial for (int i = 0; i < 8; i++) bank[i] = 8'h00;

  always_comb begin
    bus_i = 8'h00;
    for (int i = 0; i < 8; i++)
      if (rd[i]) bus_i = bank[i];
  end

  always @(posedge clk)
    if (oe)
      for (int i = 0; i < 8; i++)
        if (wr[i]) bank[i] <= bus_o;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst) begin
      if (!$onehot0(rd) || !$onehot0(wr)) inv_err++;
      if (rd != 0 && wr != 0) inv_err++;
      if (oe && rd != 0) inv_err++;
      if (!oe && (bus_o != 0 || wr != 0)) inv_err++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_xfer(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s,
                         input logic [7:0] im, input bit hold, output int lat,
                         output bit e, output logic [7:0] rdo, output logic [7:0] wro,
                         output logic [7:0] buso, output bit oes);
    int w;
    lat = 0; e = 1'b0; rdo = 8'h00; wro = 8'h00; buso = 8'h00; oes = 1'b0;
    op = o; dst = d; src = s; imm = im; req = 1'b1;
    w = 0;
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      check("ready_timeout", 0, 1);
      req = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    op = 2'($urandom); dst = 3'($urandom); src = 3'($urandom); imm = 8'($urandom);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      rdo = rdo | rd;
      wro = wro | wr;
      if (oe) begin
        oes = 1'b1;
        buso = bus_o;
      end
      if (done) begin
        lat = c;
        e = err;
        break;
      end
    end
  endtask

  // reference model: registers and flags as plain values
  logic [7:0] mreg [8];
  bit mz, ms;

  task automatic model(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s,
                       input logic [7:0] im, output int lat, output bit e,
                       output logic [7:0] rdm, output logic [7:0] wrm, output logic [7:0] val);
    e = (d == 3'd6) || (o == 2'd0 && s == 3'd6);
    lat = 1; rdm = 8'h00; wrm = 8'h00; val = 8'h00;
    if (e) return;
    wrm = 8'd1 << d;
    case (o)
      2'd0: begin val = mreg[s]; rdm = 8'd1 << s; lat = 3; end
      2'd1: begin val = im; lat = 2; end
      2'd2: begin val = mreg[d] + 8'd1; rdm = 8'd1 << d; lat = 3; mz = (val == 0); ms = val[7]; end
      default: begin val = mreg[d] - 8'd1; rdm = 8'd1 << d; lat = 3; mz = (val == 0); ms = val[7]; end
    endcase
    mreg[d] = val;
  endtask

  task automatic run_rand(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s,
                          input logic [7:0] im, input bit hold);
    int lat, mlat;
    bit e, me, oes;
    logic [7:0] rdo, wro, buso, mrd, mwr, mval;
    model(o, d, s, im, mlat, me, mrd, mwr, mval);
    do_xfer(o, d, s, im, hold, lat, e, rdo, wro, buso, oes);
    check("rnd_latency", lat, mlat);
    check("rnd_err", int'(e), int'(me));
    check("rnd_rd", int'(rdo), int'(mrd));
    check("rnd_wr", int'(wro), int'(mwr));
    check("rnd_oe", int'(oes), int'(!me));
    if (!me) check("rnd_bus", int'(buso), int'(mval));
    if (d != 3'd6) check("rnd_reg", int'(bank[d]), int'(mreg[d]));
    check("rnd_z", int'(fz), int'(mz));
    check("rnd_s", int'(fs), int'(ms));
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] dst;
    logic [2:0] src;
    logic [7:0] imm;
    int         lat;
    bit         err;
    logic [7:0] rd;
    logic [7:0] wr;
    logic [7:0] val;
    bit         z;
    bit         s;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int lat, dc;
    bit e, oes;
    logic [7:0] rdo, wro, buso;
    logic [1:0] o;

    //             op    dst   src   imm    lat err rd     wr     val    z     s
    tbl[0]  = '{2'd1, 3'd0, 3'd0, 8'h3C, 2, 1'b0, 8'h00, 8'h01, 8'h3C, 1'b0, 1'b0};
    tbl[1]  = '{2'd1, 3'd7, 3'd0, 8'h00, 2, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{2'd0, 3'd7, 3'd0, 8'h00, 3, 1'b0, 8'h01, 8'h80, 8'h3C, 1'b0, 1'b0};
    tbl[3]  = '{2'd1, 3'd5, 3'd0, 8'hA5, 2, 1'b0, 8'h00, 8'h20, 8'hA5, 1'b0, 1'b0};
    tbl[4]  = '{2'd1, 3'd1, 3'd0, 8'hFF, 2, 1'b0, 8'h00, 8'h02, 8'hFF, 1'b0, 1'b0};
    tbl[5]  = '{2'd2, 3'd1, 3'd0, 8'h00, 3, 1'b0, 8'h02, 8'h02, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{2'd3, 3'd1, 3'd0, 8'h00, 3, 1'b0, 8'h02, 8'h02, 8'hFF, 1'b0, 1'b1};
    tbl[7]  = '{2'd1, 3'd2, 3'd0, 8'h7F, 2, 1'b0, 8'h00, 8'h04, 8'h7F, 1'b0, 1'b1};
    tbl[8]  = '{2'd2, 3'd2, 3'd0, 8'h00, 3, 1'b0, 8'h04, 8'h04, 8'h80, 1'b0, 1'b1};
    tbl[9]  = '{2'd0, 3'd6, 3'd7, 8'h00, 1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{2'd0, 3'd7, 3'd6, 8'h00, 1, 1'b1, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b1};
    tbl[11] = '{2'd2, 3'd6, 3'd0, 8'h00, 1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{2'd0, 3'd0, 3'd0, 8'h00, 3, 1'b0, 8'h01, 8'h01, 8'h3C, 1'b0, 1'b1};

    #5;
    check("rst_ready", int'(ready), 0);
    check("rst_strobes", int'({rd, wr}), 0);
    check("rst_outs", int'({oe, done, err, fz, fs, bus_o}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", int'(ready), 1);

    for (int i = 0; i < 13; i++) begin
      do_xfer(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].imm, 1'b0, lat, e, rdo, wro, buso, oes);
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_err", i), int'(e), int'(tbl[i].err));
      check($sformatf("v%0d_rd", i), int'(rdo), int'(tbl[i].rd));
      check($sformatf("v%0d_wr", i), int'(wro), int'(tbl[i].wr));
      check($sformatf("v%0d_oe", i), int'(oes), int'(!tbl[i].err));
      if (!tbl[i].err) check($sformatf("v%0d_bus", i), int'(buso), int'(tbl[i].val));
      if (tbl[i].dst != 3'd6)
        check($sformatf("v%0d_reg", i), int'(bank[tbl[i].dst]), int'(tbl[i].val));
      check($sformatf("v%0d_z", i), int'(fz), int'(tbl[i].z));
      check($sformatf("v%0d_s", i), int'(fs), int'(tbl[i].s));
    end

    // reset landing in the WRITE phase of MOV E,H
    do_xfer(2'd1, 3'd4, 3'd0, 8'h11, 1'b0, lat, e, rdo, wro, buso, oes);
    do_xfer(2'd1, 3'd3, 3'd0, 8'h22, 1'b0, lat, e, rdo, wro, buso, oes);
    op = 2'd0; dst = 3'd3; src = 3'd4; req = 1'b1;
    @(negedge clk);
    check("rw_ready", int'(ready), 1);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    check("rw_read_strobe", int'(rd), 8'h10);
    @(posedge clk);
    #2;
    check("rw_write_strobe", int'(wr), 8'h08);
    check("rw_write_bus", int'(bus_o), 8'h11);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    check("rw_rst_strobes", int'({rd, wr}), 0);
    check("rw_rst_bus", int'({oe, bus_o}), 0);
    check("rw_rst_ready", int'(ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rw_ready_release", int'(ready), 1);
    check("rw_no_done", done_cnt, dc);
    check("rw_e_kept", int'(bank[3]), 8'h22);
    check("rw_flags_cleared", int'({fz, fs}), 0);
    do_xfer(2'd0, 3'd3, 3'd4, 8'h00, 1'b0, lat, e, rdo, wro, buso, oes);
    check("rw_next_latency", lat, 3);
    check("rw_next_reg", int'(bank[3]), 8'h11);

    // randomized traffic against the model
    mz = 1'b0;
    ms = 1'b0;
    for (int r = 0; r < 8; r++) mreg[r] = 8'h00;
    for (int r = 0; r < 8; r++)
      if (r != 6) run_rand(2'd1, 3'(r), 3'd0, 8'($urandom), 1'b0);

    dc = done_cnt;
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 2))
        0: o = 2'd0;
        1: o = 2'd2;
        default: o = 2'd3;
      endcase
      run_rand(o, 3'($urandom), 3'($urandom), 8'($urandom), 1'b1);
    end
    req = 1'b0;
    check("held_req_done_count", done_cnt - dc, 8);

    for (int n = 0; n < 30; n++)
      run_rand(2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 1'b0);

    repeat (3) @(negedge clk);
    check("invariants", inv_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
